// File: rtl/yolo_pkg.sv
// Shared constants, state encoding and helpers for the YOLO feature-map pipeline.
// Per-layer geometry lives here so every stage agrees on beat width and frame size.
package yolo_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int L4_NUM_CH      = 32;
    localparam int L4_IMG_SIZE    = 104;
    localparam int L4_FLUSH_BEATS = L4_IMG_SIZE + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2
    } fmap_state_e;

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_word_packer.sv
// Slot-indexed pack register: collects NUM_CH channel words into one pixel.
// pixel_o already includes the word accepted this cycle, so it is complete on pixel_full_o.
module fmap_word_packer #(
    parameter int NUM_CH     = yolo_pkg::L4_NUM_CH,
    parameter int WORD_WIDTH = yolo_pkg::WORD_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         accept_i,
    input  logic [WORD_WIDTH-1:0]        word_i,
    output logic                         pixel_full_o,
    output logic [NUM_CH*WORD_WIDTH-1:0] pixel_o
);

    localparam int CW = yolo_pkg::cnt_width(NUM_CH);
    localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);

    logic [NUM_CH-1:0][WORD_WIDTH-1:0] slots_q;
    logic [NUM_CH-1:0][WORD_WIDTH-1:0] slots_d;
    logic [CW-1:0]                     ch_cnt_q;
    logic [CW-1:0]                     ch_cnt_d;

    always_comb begin
        slots_d  = slots_q;
        ch_cnt_d = ch_cnt_q;
        if (accept_i) begin
            slots_d[ch_cnt_q] = word_i;
            ch_cnt_d = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slots_q  <= '0;
            ch_cnt_q <= '0;
        end else begin
            slots_q  <= slots_d;
            ch_cnt_q <= ch_cnt_d;
        end
    end

    assign pixel_full_o = accept_i && (ch_cnt_q == CH_LAST);
    assign pixel_o      = slots_d;

endmodule

// File: rtl/layer_4_input_packer.sv
// Layer-4 front end: packs channel-major words into raster pixel beats,
// then appends zero flush beats so the downstream 3x3 line buffers drain.
module layer_4_input_packer #(
    parameter int NUM_CH      = yolo_pkg::L4_NUM_CH,
    parameter int WORD_WIDTH  = yolo_pkg::WORD_WIDTH,
    parameter int IMG_SIZE    = yolo_pkg::L4_IMG_SIZE,
    parameter int FLUSH_BEATS = IMG_SIZE + 1
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         start,
    input  logic [WORD_WIDTH-1:0]        word_in,
    input  logic                         word_valid,
    output logic                         word_ready,
    output logic [NUM_CH*WORD_WIDTH-1:0] data_out,
    output logic                         valid_out,
    output logic                         frame_done,
    output logic                         busy
);

    import yolo_pkg::*;

    localparam int NPIX = IMG_SIZE * IMG_SIZE;
    localparam int PW   = cnt_width(NPIX);
    localparam int FW   = cnt_width(FLUSH_BEATS);
    localparam logic [PW-1:0] PIX_LAST   = PW'(NPIX - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_BEATS - 1);

    fmap_state_e                 state_q;
    logic [PW-1:0]               pix_cnt_q;
    logic [FW-1:0]               flush_cnt_q;
    logic [NUM_CH*WORD_WIDTH-1:0] data_q;
    logic                        valid_q;
    logic                        done_q;

    logic                         accept;
    logic                         pixel_full;
    logic [NUM_CH*WORD_WIDTH-1:0] pixel_vec;

    assign word_ready = (state_q == ST_FILL);
    assign accept     = word_valid && word_ready;

    fmap_word_packer #(
        .NUM_CH     (NUM_CH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_packer (
        .clk_i        (Clk),
        .rst_i        (Rst),
        .accept_i     (accept),
        .word_i       (word_in),
        .pixel_full_o (pixel_full),
        .pixel_o      (pixel_vec)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            pix_cnt_q   <= '0;
            flush_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    pix_cnt_q   <= '0;
                    flush_cnt_q <= '0;
                    if (start) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (pixel_full) begin
                        data_q  <= pixel_vec;
                        valid_q <= 1'b1;
                        if (pix_cnt_q == PIX_LAST) begin
                            state_q <= ST_FLUSH;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + PW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    // Stay in FLUSH through the frame_done beat so a start
                    // landing on that cycle is still ignored.
                    if (done_q) begin
                        state_q     <= ST_IDLE;
                        pix_cnt_q   <= '0;
                        flush_cnt_q <= '0;
                    end else begin
                        data_q  <= '0;
                        valid_q <= 1'b1;
                        if (flush_cnt_q == FLUSH_LAST) begin
                            done_q <= 1'b1;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + FW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign frame_done = done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
